// File: rtl/cla_pkg.sv
// Shared constants and carry-lookahead helpers for cla_pipe_adder and cla_group.
package cla_pkg;

    localparam int CLA_MAXN = 64;

    function automatic int num_groups_per_seg(input int width, input int group, input int stages);
        return width / (stages * group);
    endfunction

    function automatic bit cla_params_legal(input int width, input int group, input int stages);
        return (width > 0) && (group > 0) && (stages > 0) && (width <= CLA_MAXN)
            && ((width % (group * stages)) == 0);
    endfunction

    // Each carry is its own sum of products: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i:0]c0
    function automatic logic [CLA_MAXN:0] cla_carries(input logic [CLA_MAXN-1:0] p,
                                                      input logic [CLA_MAXN-1:0] g,
                                                      input logic c0,
                                                      input int n);
        logic [CLA_MAXN:0] c;
        logic term;
        logic acc;
        c = '0;
        c[0] = c0;
        for (int i = 0; i < n; i++) begin
            term = c0;
            for (int k = 0; k <= i; k++) term = term & p[k];
            acc = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) term = term & p[k];
                acc = acc | term;
            end
            c[i+1] = acc;
        end
        return c;
    endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead slice with group propagate/generate outputs.
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             ci,
    output logic [GROUP-1:0] s,
    output logic             pg,
    output logic             gg
);
    logic [CLA_MAXN-1:0] p_ext;
    logic [CLA_MAXN-1:0] g_ext;
    logic [CLA_MAXN:0]   c_zero;
    logic [CLA_MAXN:0]   c_in;

    always_comb begin
        p_ext = '0;
        g_ext = '0;
        p_ext[GROUP-1:0] = a ^ b;
        g_ext[GROUP-1:0] = a & b;
    end

    // pg/gg are kept independent of ci so the segment lookahead sees no feedback
    always_comb begin
        c_zero = cla_carries(p_ext, g_ext, 1'b0, GROUP);
        gg     = c_zero[GROUP];
        pg     = &p_ext[GROUP-1:0];
    end

    always_comb begin
        c_in = cla_carries(p_ext, g_ext, ci, GROUP);
        s    = p_ext[GROUP-1:0] ^ c_in[GROUP-1:0];
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Define CLA_PIPE_SAT_EN to clamp signed overflow to the signed max/min in the last stage.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int SEG                = WIDTH / STAGES;
    localparam int NUM_GROUPS_PER_SEG = num_groups_per_seg(WIDTH, GROUP, STAGES);
    localparam int LAST               = STAGES - 1;

    if (!cla_params_legal(WIDTH, GROUP, STAGES)) begin : g_param_check
        $error("cla_pipe_adder: WIDTH must be a multiple of GROUP*STAGES and at most 64");
    end

    logic                         en;
    logic [STAGES-1:0]            vld_p;
    // Below the active segment: finished sum bits; at and above it: operand a
    logic [STAGES-1:0][WIDTH-1:0] ar_p;
    logic [STAGES-1:0][WIDTH-1:0] b_p;
    logic [STAGES-1:0]            c_p;
    logic [STAGES-1:0][SEG-1:0]   seg_s;
    logic [STAGES-1:0]            seg_co;
    logic [STAGES-1:0][WIDTH-1:0] ar_nxt;
    logic [WIDTH-1:0]             res_fin;
    logic [WIDTH-1:0]             s_fin;
    logic                         msb_cin;
    logic                         ovf_fin;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        logic [NUM_GROUPS_PER_SEG-1:0] gp;
        logic [NUM_GROUPS_PER_SEG-1:0] gg;
        logic [CLA_MAXN-1:0]           gp_ext;
        logic [CLA_MAXN-1:0]           gg_ext;
        logic [CLA_MAXN:0]             gc;

        always_comb begin
            gp_ext = '0;
            gg_ext = '0;
            gp_ext[NUM_GROUPS_PER_SEG-1:0] = gp;
            gg_ext[NUM_GROUPS_PER_SEG-1:0] = gg;
            gc = cla_carries(gp_ext, gg_ext, c_p[k], NUM_GROUPS_PER_SEG);
        end

        for (genvar j = 0; j < NUM_GROUPS_PER_SEG; j++) begin : g_grp
            cla_group #(.GROUP(GROUP)) u_grp (
                .a  (ar_p[k][k*SEG + j*GROUP +: GROUP]),
                .b  (b_p[k][k*SEG + j*GROUP +: GROUP]),
                .ci (gc[j]),
                .s  (seg_s[k][j*GROUP +: GROUP]),
                .pg (gp[j]),
                .gg (gg[j])
            );
        end

        assign seg_co[k] = gc[NUM_GROUPS_PER_SEG];
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            ar_nxt[k] = ar_p[k];
            ar_nxt[k][k*SEG +: SEG] = seg_s[k];
        end
    end

    assign res_fin = ar_nxt[LAST];
    assign msb_cin = ar_p[LAST][WIDTH-1] ^ b_p[LAST][WIDTH-1] ^ res_fin[WIDTH-1];
    assign ovf_fin = msb_cin ^ seg_co[LAST];

`ifdef CLA_PIPE_SAT_EN
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] r,
                                                  input logic ov,
                                                  input logic a_msb);
        logic [WIDTH-1:0] lim;
        lim = {a_msb, {(WIDTH-1){!a_msb}}};
        return ov ? lim : r;
    endfunction

    assign s_fin = saturate(res_fin, ovf_fin, ar_p[LAST][WIDTH-1]);
`else
    assign s_fin = res_fin;
`endif

    // Stage boundary: operand capture, then one segment per register bank
    always_ff @(posedge clk) begin
        if (en) begin
            ar_p[0] <= a;
            b_p[0]  <= b ^ {WIDTH{sub}};
            c_p[0]  <= cin | sub;
            for (int k = 0; k < STAGES - 1; k++) begin
                ar_p[k+1] <= ar_nxt[k];
                b_p[k+1]  <= b_p[k];
                c_p[k+1]  <= seg_co[k];
            end
        end
    end

    // Stage boundary: valid chain and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p     <= '0;
            out_valid <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (en) begin
            vld_p[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) vld_p[k] <= vld_p[k-1];
            out_valid <= vld_p[LAST];
            if (vld_p[LAST]) begin
                s    <= s_fin;
                cout <= seg_co[LAST];
                ovf  <= ovf_fin;
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed table at 16 bits, random regression at 32 bits.
module tb_cla_pipe_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid16, in_ready16, cin16, sub16, out_valid16, out_ready16, cout16, ovf16;
    logic [15:0] a16, b16, s16;
    logic        in_valid32, in_ready32, cin32, sub32, out_valid32, out_ready32, cout32, ovf32;
    logic [31:0] a32, b32, s32;

    int checks = 0;
    int errors = 0;

`ifdef CLA_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    cla_pipe_adder dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .s(s16), .cout(cout16), .ovf(ovf16)
    );

    cla_pipe_adder #(.WIDTH(32), .GROUP(4), .STAGES(4)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .cin(cin32), .sub(sub32),
        .out_valid(out_valid32), .out_ready(out_ready32),
        .s(s32), .cout(cout32), .ovf(ovf32)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s_wrap;
        logic [15:0] s_sat;
        logic        cout;
        logic        ovf;
    } vec16_t;

    vec16_t tbl[9];

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: signed/unsigned arithmetic on the mathematical values; returns {ovf, cout, s}
    function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub);
        longint sa, sb, ex, lim;
        logic [63:0] mask, res;
        logic co, ov;
        mask = (64'd1 << w) - 64'd1;
        lim  = longint'(1) << (w - 1);
        sa   = a[w-1] ? longint'(a) - (lim << 1) : longint'(a);
        sb   = b[w-1] ? longint'(b) - (lim << 1) : longint'(b);
        ex   = sub ? sa - sb : sa + sb + longint'(cin);
        ov   = (ex >= lim) || (ex < -lim);
        res  = 64'(ex) & mask;
        co   = sub ? (a >= b) : (((a + b + 64'(cin)) >> w) != 64'd0);
`ifdef CLA_PIPE_SAT_EN
        if (ov) res = a[w-1] ? 64'(lim) : 64'(lim - 1);
`endif
        return {ov, co, res};
    endfunction

    task automatic run_vec16(input int idx, input vec16_t v);
        int lat;
        logic [15:0] exp_s;
        exp_s = SAT ? v.s_sat : v.s_wrap;
        @(posedge clk); #1;
        a16 = v.a; b16 = v.b; cin16 = v.cin; sub16 = v.sub;
        in_valid16 = 1'b1; out_ready16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        lat = 0;
        while (!out_valid16 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("vec%0d_latency", idx), 66'(lat), 66'd2);
        chk($sformatf("vec%0d_s", idx), 66'(s16), 66'(exp_s));
        chk($sformatf("vec%0d_cout", idx), 66'(cout16), 66'(v.cout));
        chk($sformatf("vec%0d_ovf", idx), 66'(ovf16), 66'(v.ovf));
    endtask

    task automatic lat32_vec(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        logic [65:0] e;
        int lat;
        e = model(32, {32'd0, a}, {32'd0, b}, cin, sub);
        @(posedge clk); #1;
        a32 = a; b32 = b; cin32 = cin; sub32 = sub;
        in_valid32 = 1'b1; out_ready32 = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        lat = 0;
        while (!out_valid32 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("lat32_latency", 66'(lat), 66'd4);
        chk("lat32_result", {ovf32, cout32, 32'd0, s32}, e);
    endtask

    task automatic backpressure16();
        logic [65:0] exp_q[$];
        logic [65:0] e;
        logic [15:0] va[4];
        logic [15:0] vb[4];
        int nin, got, stall_left, cyc, extra;
        bit seen;
        va = '{16'h1111, 16'h7FFF, 16'hA5A5, 16'h0F0F};
        vb = '{16'h2222, 16'h0002, 16'h5A5A, 16'hF0F1};
        nin = 0; got = 0; stall_left = 0; cyc = 0; seen = 1'b0;
        cin16 = 1'b0; sub16 = 1'b0;
        while (got < 4 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (out_valid16 && !seen) begin
                seen = 1'b1;
                stall_left = 3;
            end
            out_ready16 = (stall_left == 0);
            in_valid16  = (nin < 4);
            if (nin < 4) begin
                a16 = va[nin];
                b16 = vb[nin];
            end
            @(negedge clk);
            if (stall_left > 0) begin
                chk("bp_in_ready_low", 66'(in_ready16), 66'd0);
                if (exp_q.size() == 0) chk("bp_stall_queue", 66'd0, 66'd1);
                else chk("bp_s_held", 66'(s16), 66'(exp_q[0][15:0]));
                stall_left--;
            end else if (out_valid16 && out_ready16) begin
                if (exp_q.size() == 0) begin
                    chk("bp_spurious", 66'd1, 66'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("bp_result%0d", got), {ovf16, cout16, 48'd0, s16}, e);
                end
                got++;
            end
            if (in_valid16 && in_ready16) begin
                exp_q.push_back(model(16, {48'd0, va[nin]}, {48'd0, vb[nin]}, 1'b0, 1'b0));
                nin++;
            end
        end
        chk("bp_count", 66'(got), 66'd4);
        @(posedge clk); #1;
        in_valid16 = 1'b0; out_ready16 = 1'b1;
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid16) extra++;
        end
        chk("bp_no_duplicate", 66'(extra), 66'd0);
    endtask

    task automatic reset_midflight16();
        int stale;
        @(posedge clk); #1;
        in_valid16 = 1'b1; out_ready16 = 1'b1; cin16 = 1'b0; sub16 = 1'b0;
        a16 = 16'h0101; b16 = 16'h0202;
        @(posedge clk); #1;
        a16 = 16'h0303; b16 = 16'h0404;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmid_out_valid", 66'(out_valid16), 66'd0);
        chk("rstmid_s", 66'(s16), 66'd0);
        chk("rstmid_cout_ovf", 66'({cout16, ovf16}), 66'd0);
        stale = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid16) stale++;
        end
        chk("rstmid_no_stale", 66'(stale), 66'd0);
    endtask

    task automatic random32(input int nrand);
        logic [65:0] q[$];
        logic [65:0] e;
        int sent, cyc;
        sent = 0; cyc = 0;
        while ((sent < nrand || q.size() > 0) && cyc < 60000) begin
            @(posedge clk); #1;
            cyc++;
            in_valid32  = (sent < nrand) && ($urandom_range(0, 9) < 8);
            a32         = $urandom;
            b32         = $urandom;
            cin32       = 1'($urandom_range(0, 1));
            sub32       = 1'($urandom_range(0, 1));
            out_ready32 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (out_valid32 && out_ready32) begin
                if (q.size() == 0) begin
                    chk("rand_spurious", 66'd1, 66'd0);
                end else begin
                    e = q.pop_front();
                    chk("rand_result", {ovf32, cout32, 32'd0, s32}, e);
                end
            end
            if (in_valid32 && in_ready32) begin
                q.push_back(model(32, {32'd0, a32}, {32'd0, b32}, cin32, sub32));
                sent++;
            end
        end
        chk("rand_sent", 66'(sent), 66'(nrand));
        chk("rand_drained", 66'(q.size()), 66'd0);
        in_valid32 = 1'b0;
        out_ready32 = 1'b1;
    endtask

    initial begin
        tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 16'h0100, 1'b0, 1'b0};
        tbl[1] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
        tbl[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
        tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
        tbl[4] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 16'h5556, 1'b0, 1'b0};
        tbl[6] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 16'h0002, 1'b1, 1'b0};
        tbl[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 16'h8000, 1'b1, 1'b1};
        tbl[8] = '{16'h0FFF, 16'hF001, 1'b1, 1'b0, 16'h0001, 16'h0001, 1'b1, 1'b0};

        rst = 1'b1;
        in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
        in_valid32 = 1'b0; out_ready32 = 1'b1; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out_valid16", 66'(out_valid16), 66'd0);
        chk("reset_s16", 66'(s16), 66'd0);
        chk("reset_cout_ovf16", 66'({cout16, ovf16}), 66'd0);
        chk("reset_in_ready16", 66'(in_ready16), 66'd1);
        chk("reset_out_valid32", 66'(out_valid32), 66'd0);
        chk("reset_in_ready32", 66'(in_ready32), 66'd1);

        for (int i = 0; i < 9; i++) run_vec16(i, tbl[i]);

        backpressure16();
        reset_midflight16();

        lat32_vec(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
        lat32_vec(32'h80000000, 32'h00000001, 1'b1, 1'b1);
        lat32_vec(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0);

        random32(10000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshake, the successor to the fixed 16-bit two-level CLA used in the FIR datapath. Operands of WIDTH bits are split into STAGES segments. Each segment is a two-level lookahead tree of GROUP-bit CLA groups. The carry ripples between segments through pipeline registers, so the adder closes timing at WIDTH up to 64. It sits between the Booth partial-product reducer and the FIR accumulator, and supports add, subtract, and stall-safe back-pressure.

## Interface
- WIDTH, 16, operand/result width; WIDTH % (GROUP*STAGES) == 0
- GROUP, 4, bits per lookahead group (group P/G generated per GROUP bits)
- STAGES, 2, pipeline depth; segment width SEG = WIDTH/STAGES
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operands valid
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  operand A (two's complement)
- b  in  WIDTH  operand B
- cin  in  1  carry-in (ignored when sub=1)
- sub  in  1  1: compute a - b (b inverted, carry-in forced 1)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- s  out  WIDTH  sum/difference, low WIDTH bits
- cout  out  1  carry-out of MSB (borrow-not for sub)
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB

## Operation
- Transfer rules: input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Stage k (0..STAGES-1) computes bits [k*SEG +: SEG] from the registered carry of stage k-1. Stage 0 uses cin, or 1 when sub=1.
- Inside a segment, group P/G feed one lookahead level. Group carries: c[i+1] = G[i] | P[i]&c[i], flattened, no ripple between groups.
- Operand bits above the current segment travel down the pipe in skew registers. Result bits below it travel down in deskew registers. All bits of one transaction emerge together.
- sub is applied at input capture: b is XOR-ed with sub before registering. sub does not travel down the pipe.
- ovf uses the carry into the MSB of the last segment and cout.
- Stall: global pipeline enable en = !out_valid || out_ready. in_ready = en. When en=0, every data and valid register holds.
- No bubbles are inserted. The pipeline sustains one result per cycle when out_ready is held high.
- The valid bit shifts with data. Invalid slots still advance when en=1, so bubbles collapse only at the output.

## Timing
- Reset: out_valid=0, s=0, cout=0, ovf=0, all internal valid bits 0. in_ready=1 in the first cycle after reset.
- Latency: STAGES cycles from input transfer to out_valid. For the default, operands accepted at edge N are valid after edge N+2.
- Throughput: 1 transaction/cycle.
- Back-pressure with out_ready low: s/cout/ovf stay stable while out_valid=1. in_ready drops combinationally in the same cycle.
- Simultaneous output transfer and input capture in the same cycle is allowed; nothing is lost.
- rst asserted mid-operation: all in-flight transactions are discarded at the next edge. Outputs return to reset values.
- in_ready depends combinationally on out_ready. There is no combinational path from a/b to s.

## Configuration
- CLA_PIPE_SAT_EN defined: adds a final saturation step in the last stage. On ovf=1, s is clamped to the signed maximum (0x7FFF for WIDTH=16) when the MSB of a is 0, else to the signed minimum (0x8000). ovf is still reported, and cout is unchanged. Latency is unchanged.
- CLA_PIPE_SAT_EN undefined: s wraps modulo 2^WIDTH. No saturation logic is built.

## Structure
- Shared package cla_pkg holds:
  - the helper function computing carries from a P/G vector and carry-in;
  - the constant NUM_GROUPS_PER_SEG = SEG/GROUP;
  - elaboration checks on the parameter legality rules.
- Sub-module cla_group: a combinational GROUP-bit CLA with outputs s, pg, gg. It is instantiated NUM_GROUPS_PER_SEG times per segment.
- The top level owns all registers: the skew/deskew shift registers, the per-stage carry registers, the valid chain, and the saturation logic.

## Test plan
All scenarios use the defaults (WIDTH=16, GROUP=4, STAGES=2) unless noted.
- Carry ripples across segments: a=0x00FF, b=0x0001, cin=0, sub=0 -> after 2 cycles s=0x0100, cout=0, ovf=0.
- Subtract with borrow: a=0x0000, b=0x0001, sub=1 -> s=0xFFFF, cout=0, ovf=0.
  - Then a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, ovf=1.
- Signed overflow on add: a=0x7FFF, b=0x0001 -> s=0x8000, ovf=1, cout=0.
  - With CLA_PIPE_SAT_EN defined: s=0x7FFF, ovf=1.
- Back-pressure: stream 4 back-to-back transactions and hold out_ready=0 for 3 cycles at the 1st result.
  - Required: in_ready=0 during the stall, s held stable, all 4 results delivered in order with none duplicated.
- Reset mid-flight: issue 2 transactions, assert rst one cycle later.
  - Required: out_valid=0 and s=0 the cycle after rst, no stale result appears afterwards.
- Random regression: 10k random a/b/cin/sub with random out_ready at WIDTH=32, STAGES=4, GROUP=4.
  - Required: every result matches the {cout,s} = a ± b + cin reference model at latency 4 when unstalled.
